uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Sticky frame-error and overrun flags are kept for status polling.
//
// Handshake: rx_valid=1 means rd_data holds the FIFO head. A pop happens on
// the rising edge where rd_en=1 and rx_valid=1. rd_en while rx_valid=0 is
// ignored. The receive side has no back-pressure: a byte completing while
// the FIFO is full is dropped and raises overrun, unless a pop happens in the
// same cycle.
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_bit,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [7:0]       rd_data,
    output logic             rx_valid,
    output logic [CNT_W-1:0] fifo_count,
    output logic             frame_err,
    output logic             overrun,
    output logic [2:0]       dbg_state
);

    localparam int BW = $clog2(BAUD_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0]    HALF_M1 = BW'(BAUD_DIV / 2 - 1);
    localparam logic [BW-1:0]    FULL_M1 = BW'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;
    logic          push_req;
    logic          ferr_set;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             pop;
    logic             do_push;
    logic             ovr_set;
    logic             full;

    // Two-flop synchronizer input; rx_bit is asynchronous to clock.
    always_comb begin
        rx_meta_d = rx_bit;
        rx_s_d    = rx_meta_q;
    end

    // Receiver FSM next-state: timing counters, bit index and shift register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    // Centre of the start bit: a high line here was a glitch.
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + BW'(1);
                end
            end
            S_BREAK: begin
                // Hold off until the line returns high so a stuck-low line
                // cannot produce a stream of false frames.
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO and error-flag next-state: push/pop arbitration, pointers, count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        full     = (count_q == DEPTH_C);
        pop      = rd_en && (count_q != '0);
        // A pop in the same cycle frees the slot the incoming byte needs.
        do_push  = push_req && (!full || pop);
        ovr_set  = push_req && full && !pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + {{(CNT_W-1){1'b0}}, do_push}
                          - {{(CNT_W-1){1'b0}}, pop};
        // Set wins over a simultaneous clear.
        frame_err_d = ferr_set || (frame_err_q && !err_clr);
        overrun_d   = ovr_set  || (overrun_q   && !err_clr);
    end

    // State register for synchronizer, FSM, FIFO and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_valid   = (count_q != '0);
    assign rd_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames driven bit-by-bit, checks at negedge.
module tb_uart_rx_fifo;

  localparam int BAUD = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx_bit;
  logic       rx_drv;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;

  // transmitter model used for loopback
  logic       loop_en = 1'b0;
  logic       tx_bit = 1'b1;
  logic       tx_go = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic [9:0] tx_sh = 10'h3ff;
  int         tx_cnt = 0;
  int         tx_tick = 0;

  assign rx_bit = loop_en ? tx_bit : rx_drv;

  uart_rx_fifo #(.BAUD_DIV(BAUD), .FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .rx_bit(rx_bit), .rd_en(rd_en),
    .err_clr(err_clr), .rd_data(rd_data), .rx_valid(rx_valid),
    .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // records the cycle on which rx_valid rises
  always @(negedge clock) begin
    if (rx_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rx_valid;
  end

  // 8N1 serializer model
  always @(posedge clock) begin
    if (tx_cnt != 0) begin
      if (tx_tick == BAUD - 1) begin
        tx_tick <= 0;
        tx_cnt  <= tx_cnt - 1;
        tx_sh   <= {1'b1, tx_sh[9:1]};
        tx_bit  <= (tx_cnt == 1) ? 1'b1 : tx_sh[1];
      end else begin
        tx_tick <= tx_tick + 1;
      end
    end else if (tx_go) begin
      tx_sh   <= {1'b1, tx_byte, 1'b0};
      tx_cnt  <= 10;
      tx_tick <= 0;
      tx_bit  <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // drives one frame starting at a negedge; optional rd_en on the push cycle
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic pop_stop);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = fr[i];
      for (int k = 0; k < BAUD; k++) begin
        if (pop_stop) rd_en = (i == 9 && k == 10);
        @(negedge clock);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    chk({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp});
    rd_en = 1'b1;
    @(negedge clock);
    rd_en = 1'b0;
  endtask

  task automatic tx_send(input logic [7:0] b);
    int n;
    tx_byte = b;
    tx_go = 1'b1;
    @(negedge clock);
    tx_go = 1'b0;
    n = 0;
    while (tx_cnt != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("tx_done", {31'd0, (tx_cnt == 0)}, 32'd1);
  endtask

  initial begin
    int c;
    int lat;
    int n;
    reset = 1'b1; rx_drv = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_data", {24'd0, rd_data}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, overrun}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    // basic frame 0xA5 and latency
    c = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    lat = rise_cyc - c;
    chk("a5_latency_window", {31'd0, (lat >= 152 && lat <= 156)}, 32'd1);
    chk("a5_count", {29'd0, fifo_count}, 32'd1);
    read_chk("a5", 8'hA5);
    chk("a5_empty", {31'd0, rx_valid}, 32'd0);
    chk("a5_count0", {29'd0, fifo_count}, 32'd0);

    // rd_en while empty is ignored
    rd_en = 1'b1; @(negedge clock); rd_en = 1'b0;
    chk("empty_rd_count", {29'd0, fifo_count}, 32'd0);

    // glitch rejection
    rx_drv = 1'b0;
    repeat (4) @(negedge clock);
    rx_drv = 1'b1;
    repeat (20) @(negedge clock);
    chk("glitch_state", {29'd0, dbg_state}, 32'd0);
    chk("glitch_count", {29'd0, fifo_count}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    read_chk("3c", 8'h3C);

    // framing error and break
    send_frame(8'h55, 1'b0, 1'b0);
    rx_drv = 1'b0;
    repeat (40) @(negedge clock);
    chk("ferr_set", {31'd0, frame_err}, 32'd1);
    chk("ferr_count", {29'd0, fifo_count}, 32'd0);
    chk("ferr_break", {29'd0, dbg_state}, 32'd4);
    rx_drv = 1'b1;
    repeat (10) @(negedge clock);
    chk("break_idle", {29'd0, dbg_state}, 32'd0);
    send_frame(8'h0F, 1'b1, 1'b0);
    read_chk("0f", 8'h0F);
    chk("ferr_sticky", {31'd0, frame_err}, 32'd1);
    err_clr = 1'b1; @(negedge clock); err_clr = 1'b0;
    chk("ferr_clr", {31'd0, frame_err}, 32'd0);

    // overrun with back-to-back frames
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_count", {29'd0, fifo_count}, 32'd4);
    for (int i = 1; i <= 4; i++) read_chk("ovr_rd", 8'(i));
    chk("ovr_empty", {31'd0, rx_valid}, 32'd0);
    err_clr = 1'b1; @(negedge clock); err_clr = 1'b0;
    chk("ovr_clr", {31'd0, overrun}, 32'd0);

    // full FIFO with pop on the push cycle
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    send_frame(8'h05, 1'b1, 1'b1);
    repeat (4) @(negedge clock);
    chk("pp_ovr", {31'd0, overrun}, 32'd0);
    chk("pp_count", {29'd0, fifo_count}, 32'd4);
    for (int i = 2; i <= 5; i++) read_chk("pp_rd", 8'(i));
    chk("pp_empty", {31'd0, rx_valid}, 32'd0);

    // reset mid-frame of 0xFF
    rx_drv = 1'b0;
    repeat (BAUD) @(negedge clock);
    rx_drv = 1'b1;
    repeat (40) @(negedge clock);
    chk("mid_data_state", {29'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
    reset = 1'b0;
    repeat (120) @(negedge clock);
    chk("mid_rst_nopush", {29'd0, fifo_count}, 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    read_chk("81", 8'h81);

    // loopback from the transmitter model
    loop_en = 1'b1;
    repeat (4) @(negedge clock);
    tx_send(8'h48);
    tx_send(8'h69);
    n = 0;
    while (fifo_count < 3'd2 && n < 500) begin
      @(negedge clock);
      n++;
    end
    chk("lb_count", {29'd0, fifo_count}, 32'd2);
    read_chk("lb0", 8'h48);
    read_chk("lb1", 8'h69);
    chk("lb_ferr", {31'd0, frame_err}, 32'd0);
    chk("lb_ovr", {31'd0, overrun}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
